// File: rtl/sat_accum_seq.sv
`timescale 1ns/1ps
// Frame accumulator feeding an external 16-bit saturating adder: sums N_SAMPLES signed
// samples (valid/ready in), then offers the saturated total downstream (valid/ready out).
module sat_accum_seq #(
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [15:0] in_data,
    output logic        in_rdy,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_sum,
    output logic        out_vld,
    output logic [15:0] out_data,
    input  logic        out_rdy,
    output logic        sat_flag,
    output logic [1:0]  fsm_state
);

    // Handshake rule on both sides: a transfer happens on a rising clk edge where
    // vld and rdy are both high; vld never depends on rdy of the same interface.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [15:0]        acc;
    logic [CNT_W-1:0]   cnt;
    logic               xfer;
    logic [16:0]        raw_sum;
    logic               ovf;

    assign in_rdy    = (state != DONE);
    assign out_vld   = (state == DONE);
    assign out_data  = acc;
    assign add_a     = acc;
    assign add_b     = in_data;
    assign fsm_state = state;
    assign xfer      = in_vld & in_rdy;

    // Local overflow detect: 17-bit sign-extended sum disagrees in its top two bits
    // exactly when both operands share a sign and the 16-bit result flips it.
    assign raw_sum = {acc[15], acc} + {in_data[15], in_data};
    assign ovf     = raw_sum[16] ^ raw_sum[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= 16'h0000;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            acc      <= 16'h0000;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        acc      <= add_sum;
                        cnt      <= CNT_W'(1);
                        sat_flag <= ovf;
                        state    <= (N_SAMPLES == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= add_sum;
                        cnt <= cnt + CNT_W'(1);
                        if (ovf) sat_flag <= 1'b1;
                        if (cnt == CNT_W'(N_SAMPLES - 1)) state <= DONE;
                    end
                end
                DONE: begin
                    // sat_flag is left alone so the result's status stays readable
                    if (out_rdy) begin
                        state <= IDLE;
                        acc   <= 16'h0000;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sat_accum_seq.sv
`timescale 1ns/1ps
// Directed bench for sat_accum_seq with a behavioural saturating adder on the add_* loop.
module tb_sat_accum_seq;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_vld;
    logic [15:0] in_data;
    logic        in_rdy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        out_vld;
    logic [15:0] out_data;
    logic        out_rdy;
    logic        sat_flag;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    sat_accum_seq #(.N_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
        .sat_flag(sat_flag), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Upstream adder: pos+pos overflow -> 7FFF, neg+neg overflow -> 8001
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        s = a + b;
        if (!a[15] && !b[15] && s[15]) return 16'h7FFF;
        if (a[15] && b[15] && !s[15])  return 16'h8001;
        return s;
    endfunction

    always_comb add_sum = sat_add(add_a, add_b);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one sample; returns #1 after the edge that consumed it
    task automatic push(input logic [15:0] d);
        int t;
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = d;
        t = 0;
        while (!in_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy) check("push_timeout", 16'(in_rdy), 16'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic push4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        push(a); push(b); push(c); push(d);
    endtask

    // wait for the result, score it against the queue, then complete the handshake
    task automatic collect(input string tag, input logic exp_sat);
        int t;
        logic [15:0] exp_d;
        t = 0;
        while (!out_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_vld"}, 16'(out_vld), 16'd1);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_sat"}, 16'(sat_flag), 16'(exp_sat));
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check({tag, "_idle_vld"}, 16'(out_vld), 16'd0);
        check({tag, "_idle_rdy"}, 16'(in_rdy), 16'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        in_vld  = 1'b0;
        in_data = 16'h0000;
        out_rdy = 1'b0;
        #12;
        check("rst_out_vld", 16'(out_vld), 16'd0);
        check("rst_in_rdy", 16'(in_rdy), 16'd1);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_sat", 16'(sat_flag), 16'd0);
        check("rst_state", 16'(fsm_state), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: out_rdy held high throughout; early out_rdy must be ignored
        out_rdy = 1'b1;
        push(16'd1); push(16'd2); push(16'd3);
        check("t1_vld_early", 16'(out_vld), 16'd0);
        check("t1_acc3", out_data, 16'h0006);
        push(16'd4);
        check("t1_vld", 16'(out_vld), 16'd1);
        check("t1_data", out_data, 16'h000A);
        check("t1_sat", 16'(sat_flag), 16'd0);
        check("t1_in_rdy", 16'(in_rdy), 16'd0);
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check("t1_after_vld", 16'(out_vld), 16'd0);
        check("t1_after_data", out_data, 16'h0000);

        // T2: positive saturation, then a -1 walks back off the rail
        push(16'h7000); push(16'h2000);
        check("t2_sat_mid", out_data, 16'h7FFF);
        push(16'h0001); push(16'hFFFF);
        exp_q.push_back(16'h7FFE);
        collect("t2", 1'b1);

        // T3: negative saturation lands on 8001; next frame clears the flag
        push(16'h8000); push(16'hF000);
        check("t3_sat_mid", out_data, 16'h8001);
        push(16'h0000); push(16'h0000);
        exp_q.push_back(16'h8001);
        collect("t3a", 1'b1);
        push4(16'd1, 16'd1, 16'd1, 16'd1);
        exp_q.push_back(16'h0004);
        collect("t3b", 1'b0);

        // T4: hold result under backpressure with a pending sample
        push4(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = 16'h0063;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_rdy", 16'(in_rdy), 16'd0);
            check("t4_hold", out_data, 16'h000A);
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        in_vld  = 1'b0;
        check("t4_release", 16'(fsm_state), 16'd0);
        push(16'h0063); push(16'd1); push(16'd1); push(16'd1);
        exp_q.push_back(16'h0066);
        collect("t4", 1'b0);

        // T5: clr beats a concurrent valid sample and clears sat_flag
        push(16'h7000); push(16'h2000);
        check("t5_pre_sat", 16'(sat_flag), 16'd1);
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = 16'h0009;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        in_vld = 1'b0;
        check("t5_acc", out_data, 16'h0000);
        check("t5_state", 16'(fsm_state), 16'd0);
        check("t5_sat", 16'(sat_flag), 16'd0);
        push4(16'd5, 16'd5, 16'd5, 16'd5);
        exp_q.push_back(16'h0014);
        collect("t5", 1'b0);

        // T6: async reset mid-frame and mid-DONE
        push(16'd1); push(16'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6a_vld", 16'(out_vld), 16'd0);
        check("t6a_rdy", 16'(in_rdy), 16'd1);
        check("t6a_data", out_data, 16'h0000);
        #2;
        rst_n = 1'b1;
        push4(16'h7000, 16'h2000, 16'd1, 16'd1);
        check("t6b_done", 16'(out_vld), 16'd1);
        check("t6b_sat_pre", 16'(sat_flag), 16'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6b_vld", 16'(out_vld), 16'd0);
        check("t6b_rdy", 16'(in_rdy), 16'd1);
        check("t6b_sat", 16'(sat_flag), 16'd0);
        check("t6b_data", out_data, 16'h0000);
        #2;
        rst_n = 1'b1;
        push4(16'd2, 16'd3, 16'd4, 16'd5);
        exp_q.push_back(16'h000E);
        collect("t6", 1'b0);

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
